mdu_seq: RTL and testbench

- Iterative sequencer for the RV32M MUL/DIV group. It runs instructions the decoder flags as 32-bit M-extension ops.
- Captures operands on a start strobe and runs a 32-step shift-add multiply or restoring divide. It applies sign fix-up and special-case results, then returns one result with a one-cycle done pulse.
- Sits beside the ALU in the execute stage. Its busy output stalls the pipeline while an op is in flight.

---
 rtl/mdu_seq.sv | 176 +++++++++++++++++
 tb/tb_mdu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide,
// sign fix-up and special-case results, one-cycle done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; result held; done pulses here after FINAL
// S_CALC  | one shift-add / restoring-divide iteration per cycle, cnt 0..31
// S_FINAL | sign fix-up / special-case select, result registered
module mdu_seq #(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept, finish;

  logic [2:0]      op;
  logic            sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] a_raw;

  // operand decode at acceptance
  logic            sa_en, sb_en, sa_in, sb_in;
  logic            is_div_in, zero_in, ovf_in, special_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  always_comb begin
    is_div_in  = func3[2];
    sa_en      = func3[2] ? ~func3[0] : (func3[0] ^ func3[1]);
    sb_en      = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
    sa_in      = sa_en & rs1_data[XLEN-1];
    sb_in      = sb_en & rs2_data[XLEN-1];
    mag_a_in   = sa_in ? -rs1_data : rs1_data;
    mag_b_in   = sb_in ? -rs2_data : rs2_data;
    zero_in    = is_div_in && (rs2_data == '0);
    ovf_in     = is_div_in && !func3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
    special_in = (FAST_SPECIAL != 0) && (zero_in || ovf_in);
  end

  // one iteration of each datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_trial;
  logic            div_ge;

  always_comb begin
    mul_sum   = acc + {1'b0, (lo[0] ? opa : {XLEN{1'b0}})};
    div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opa};
    div_ge    = ~div_trial[XLEN+1];
  end

  // sign fix-up and special-case select
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

  always_comb begin
    prod     = {acc[XLEN-1:0], lo};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo_fix  = (sign_a ^ sign_b) ? -lo : lo;
    rem_fix  = sign_a ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    case (op)
      3'b000:                 final_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero)     final_val = '1;
        else if (div_ovf) final_val = INT_MIN;
        else              final_val = quo_fix;
      end
      default: begin
        if (div_zero)     final_val = a_raw;
        else if (div_ovf) final_val = '0;
        else              final_val = rem_fix;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !kill) begin
          accept    = 1'b1;
          state_nxt = special_in ? S_FINAL : S_CALC;
        end
      end
      S_CALC: begin
        if (kill)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        finish    = !kill;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      lo       <= '0;
      opa      <= '0;
      a_raw    <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        op       <= func3;
        sign_a   <= sa_in;
        sign_b   <= sb_in;
        div_zero <= zero_in;
        div_ovf  <= ovf_in;
        a_raw    <= rs1_data;
        cnt      <= '0;
        acc      <= '0;
        // divide keeps the dividend in lo and shifts quotient bits in behind it;
        // multiply keeps the multiplier in lo and shifts product bits in from the top
        lo       <= is_div_in ? mag_a_in : mag_b_in;
        opa      <= is_div_in ? mag_b_in : mag_a_in;
      end else if (state == S_CALC && !kill) begin
        cnt <= cnt + 1'b1;
        if (op[2]) begin
          acc <= div_ge ? div_trial[XLEN:0] : div_shift;
          lo  <= {lo[XLEN-2:0], div_ge};
        end else begin
          acc <= {1'b0, mul_sum[XLEN:1]};
          lo  <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end
      if (finish) result <= final_val;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table for results/latency, plus hand-written
// sequences for kill, ignored start, back-to-back and mid-op reset.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mdu_seq #(.XLEN(32), .FAST_SPECIAL(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .func3    (func3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_res;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input bit special);
    vec_t v;
    v.name = name; v.f = f; v.a = a; v.b = b; v.exp = exp; v.special = special;
    vecs.push_back(v);
  endtask

  // call at a negedge; returns at the negedge of the done cycle (or after budget)
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int          lat = 0;
    logic        busy_ok = 1'b1;
    logic        busy_at_done = 1'b1;
    logic [31:0] res = '0;
    func3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        func3 = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      if (done) begin
        lat = k; res = result; busy_at_done = busy;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, res, exp_res);
    chk({name, " busy in flight"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " busy at done"}, {31'b0, busy_at_done}, 32'd0);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, " done single pulse"}, {31'b0, done}, 32'd0);
    chk({name, " idle busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    int done_at;
    bit early;

    reset = 1'b1; start = 1'b0; kill = 1'b0;
    func3 = '0; rs1_data = '0; rs2_data = '0;

    add("MUL 7*-3",          MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    add("MULH min*min",      MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
    add("MULHU max*max",     MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    add("MULHSU -1*max",     MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    add("MULH 7fff^2",       MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 0);
    add("MULH -1*2",         MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0);
    add("DIV -7/2",          DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    add("REM -7/2",          REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    add("DIVU 100/7",        DIVU,   32'd100,      32'd7,        32'd14,       0);
    add("REMU 100/7",        REMU,   32'd100,      32'd7,        32'd2,        0);
    add("DIV -100/-7",       DIV,    32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       0);
    add("REM -100/-7",       REM,    32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 0);
    add("REM 7/-2",          REM,    32'd7,        32'hFFFFFFFE, 32'd1,        0);
    add("DIVU min/max",      DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    add("DIVU 5/0",          DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add("REM 5/0",           REM,    32'd5,        32'd0,        32'd5,        1);
    add("DIV -7/0",          DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
    add("REMU -7/0",         REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    add("DIV overflow",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add("REM overflow",      REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset busy",   {31'b0, busy}, 32'd0);
    chk("reset done",   {31'b0, done}, 32'd0);
    chk("reset result", result,        32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].special ? 2 : 34, vecs[i].exp);
      last_res = vecs[i].exp;
      idle_check(vecs[i].name);
    end

    // kill during CALC, then restart at N+12
    func3 = MUL; rs1_data = 32'd7; rs2_data = 32'd3; start = 1'b1;
    early = 0;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) kill = 1'b1;
      if (k == 11) begin
        kill = 1'b0;
        chk("kill busy drop", {31'b0, busy}, 32'd0);
        chk("kill result held", result, last_res);
      end
      if (k == 12) begin
        func3 = DIVU; rs1_data = 32'd9; rs2_data = 32'd3; start = 1'b1;
      end
      if (k == 13) start = 1'b0;
      if (k < 46 && done) early = 1;
      if (k == 40) chk("kill no result change", result, last_res);
      if (k == 46) begin
        chk("restart done", {31'b0, done}, 32'd1);
        chk("restart result", result, 32'd3);
      end
    end
    chk("kill no done", {31'b0, early}, 32'd0);
    last_res = 32'd3;
    idle_check("restart");

    // kill in FINAL of a special-case op
    func3 = DIVU; rs1_data = 32'd5; rs2_data = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("final kill done", {31'b0, done}, 32'd0);
    chk("final kill busy", {31'b0, busy}, 32'd0);
    chk("final kill result", result, last_res);

    // kill beats start in IDLE
    func3 = DIVU; rs1_data = 32'd5; rs2_data = 32'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("idle kill busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("idle kill done", {31'b0, done}, 32'd0);

    // start while busy ignored; start in done cycle accepted
    func3 = MUL; rs1_data = 32'd7; rs2_data = 32'd3; start = 1'b1;
    dones = 0; done_at = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        func3 = DIVU; rs1_data = 32'd8; rs2_data = 32'd0; start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        dones++; done_at = k;
      end
    end
    chk("ignore done count", 32'(dones), 32'd1);
    chk("ignore done cycle", 32'(done_at), 32'd34);
    chk("ignore result", result, 32'd21);
    run_op("b2b DIV 10/3", DIV, 32'd10, 32'd3, 34, 32'd3);
    idle_check("b2b");

    // reset mid-op
    func3 = MUL; rs1_data = 32'd7; rs2_data = 32'd3; start = 1'b1;
    early = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 20) reset = 1'b1;
      if (k == 21) begin
        reset = 1'b0;
        chk("mid reset busy", {31'b0, busy}, 32'd0);
        chk("mid reset result", result, 32'd0);
      end
      if (done) early = 1;
    end
    chk("mid reset no done", {31'b0, early}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
